// File: rtl/fp_divider.sv
// Iterative binary32 divider: one-cycle special-case resolution, pre-normalisation of
// finite operands, then a restoring divider producing one quotient bit per cycle.
module fp_divider (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] O,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_NORM = 3'd1,
        S_DIV  = 3'd2,
        S_PACK = 3'd3,
        S_DONE = 3'd4
    } state_t;

    function automatic logic f_is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
    endfunction

    function automatic logic f_is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
    endfunction

    function automatic logic f_is_zero(input logic [31:0] x);
        return x[30:0] == 31'h0;
    endfunction

    function automatic logic [23:0] f_mant(input logic [31:0] x);
        return {(x[30:23] != 8'h00), x[22:0]};
    endfunction

    // Denormals carry the same scale as exponent field 1.
    function automatic logic signed [9:0] f_exp(input logic [31:0] x);
        return (x[30:23] == 8'h00) ? 10'sd1 : $signed({2'b00, x[30:23]});
    endfunction

    state_t             state_q, state_d;
    logic [23:0]        ma_q, ma_d, mb_q, mb_d;
    logic signed [9:0]  ea_q, ea_d, eb_q, eb_d;
    logic               sign_q, sign_d;
    logic [25:0]        rem_q, rem_d;
    logic [24:0]        quo_q, quo_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [31:0]        o_q, o_d;

    logic               a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s, sign_s;
    logic               rem_ge_s;
    logic [25:0]        rem_sub_s;
    logic signed [9:0]  e_pack_s;
    logic [22:0]        mant_pack_s;

    assign a_nan_s   = f_is_nan(A);
    assign b_nan_s   = f_is_nan(B);
    assign a_inf_s   = f_is_inf(A);
    assign b_inf_s   = f_is_inf(B);
    assign a_zero_s  = f_is_zero(A);
    assign b_zero_s  = f_is_zero(B);
    assign sign_s    = A[31] ^ B[31];

    assign rem_ge_s  = rem_q >= {2'b00, mb_q};
    assign rem_sub_s = rem_q - {2'b00, mb_q};

    // A quotient below 1.0 needs one extra bit of left alignment and one less exponent.
    assign e_pack_s    = ea_q - eb_q + (quo_q[24] ? 10'sd127 : 10'sd126);
    assign mant_pack_s = quo_q[24] ? quo_q[23:1] : quo_q[22:0];

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign O         = o_q;

    // Next-state and datapath update for every state.
    always_comb begin
        state_d = state_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        ea_d    = ea_q;
        eb_d    = eb_q;
        sign_d  = sign_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        o_d     = o_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_DONE;
                    if (a_nan_s) begin
                        o_d = A;
                    end else if (b_nan_s) begin
                        o_d = B;
                    end else if ((a_inf_s && b_inf_s) || (a_zero_s && b_zero_s)) begin
                        o_d = 32'h7FC0_0000;
                    end else if (a_inf_s || b_zero_s) begin
                        o_d = {sign_s, 8'hFF, 23'h0};
                    end else if (b_inf_s || a_zero_s) begin
                        o_d = {sign_s, 31'h0};
                    end else begin
                        state_d = S_NORM;
                        sign_d  = sign_s;
                        ma_d    = f_mant(A);
                        mb_d    = f_mant(B);
                        ea_d    = f_exp(A);
                        eb_d    = f_exp(B);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_NORM: begin
                if (ma_q[23] && mb_q[23]) begin
                    state_d = S_DIV;
                    rem_d   = {2'b00, ma_q};
                    quo_d   = 25'h0;
                    cnt_d   = 5'd24;
                end else begin
                    if (!ma_q[23]) begin
                        ma_d = {ma_q[22:0], 1'b0};
                        ea_d = ea_q - 10'sd1;
                    end else begin
                        ma_d = ma_q;
                    end
                    if (!mb_q[23]) begin
                        mb_d = {mb_q[22:0], 1'b0};
                        eb_d = eb_q - 10'sd1;
                    end else begin
                        mb_d = mb_q;
                    end
                end
            end
            S_DIV: begin
                quo_d = {quo_q[23:0], rem_ge_s};
                rem_d = (rem_ge_s ? rem_sub_s : rem_q) << 1;
                if (cnt_q == 5'd0) begin
                    state_d = S_PACK;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            S_PACK: begin
                state_d = S_DONE;
                if (e_pack_s >= 10'sd255) begin
                    o_d = {sign_q, 8'hFF, 23'h0};
                end else if (e_pack_s <= 10'sd0) begin
                    o_d = {sign_q, 31'h0};
                end else begin
                    o_d = {sign_q, e_pack_s[7:0], mant_pack_s};
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            ma_q    <= 24'h0;
            mb_q    <= 24'h0;
            ea_q    <= 10'sd0;
            eb_q    <= 10'sd0;
            sign_q  <= 1'b0;
            rem_q   <= 26'h0;
            quo_q   <= 25'h0;
            cnt_q   <= 5'd0;
            o_q     <= 32'h0;
        end else begin
            state_q <= state_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            sign_q  <= sign_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
        end
    end

endmodule

// File: tb/tb_fp_divider.sv
// Randomised and directed bench for fp_divider against an arithmetic reference model.
module tb_fp_divider;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [31:0] A = 32'h0;
    logic [31:0] B = 32'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] O;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode = 0;

    typedef struct {
        logic [31:0] o;
        int          lat;
        int          acc;
        bit          seen;
    } exp_t;
    exp_t exp_q[$];

    fp_divider dut (
        .clk(clk), .n_rst(n_rst), .A(A), .B(B), .in_valid(in_valid), .in_ready(in_ready),
        .O(O), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Consumer readiness: 0 = always ready, 1 = stalled, otherwise random.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
    endfunction
    function automatic bit is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
    endfunction
    function automatic bit is_zero(input logic [31:0] x);
        return x[30:0] == 31'h0;
    endfunction
    function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
        return is_nan(a) || is_nan(b) || is_inf(a) || is_inf(b) || is_zero(a) || is_zero(b);
    endfunction

    // Leading zeros of the 24-bit significand (hidden bit included).
    function automatic int lz(input logic [31:0] x);
        logic [23:0] m;
        int n;
        m = {(x[30:23] != 8'h00), x[22:0]};
        n = 0;
        while (!m[23] && n < 24) begin
            m = m << 1;
            n++;
        end
        return n;
    endfunction

    function automatic logic [31:0] model_o(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          ea, eb, e;
        logic [47:0] num, den, q;
        logic [22:0] mant;
        s = a[31] ^ b[31];
        if (is_nan(a)) return a;
        if (is_nan(b)) return b;
        if ((is_inf(a) && is_inf(b)) || (is_zero(a) && is_zero(b))) return 32'h7FC0_0000;
        if (is_inf(a) || is_zero(b)) return {s, 8'hFF, 23'h0};
        if (is_inf(b) || is_zero(a)) return {s, 31'h0};
        ea  = (a[30:23] == 8'h00) ? 1 : int'(a[30:23]);
        eb  = (b[30:23] == 8'h00) ? 1 : int'(b[30:23]);
        ea  = ea - lz(a);
        eb  = eb - lz(b);
        num = {24'h0, a[30:23] != 8'h00, a[22:0]} << (24 + lz(a));
        den = {24'h0, b[30:23] != 8'h00, b[22:0]} << lz(b);
        q   = num / den;
        if (q[24]) begin
            mant = q[23:1];
            e    = ea - eb + 127;
        end else begin
            mant = q[22:0];
            e    = ea - eb + 126;
        end
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        return {s, 8'(e), mant};
    endfunction

    function automatic int model_lat(input logic [31:0] a, input logic [31:0] b);
        int da, db;
        if (is_special(a, b)) return 1;
        da = lz(a);
        db = lz(b);
        return 28 + ((da > db) ? da : db);
    endfunction

    // Compare process: handshake bookkeeping, latency and result checks each cycle.
    always @(negedge clk) begin
        if (n_rst) begin
            chk32("in_ready", {31'h0, in_ready}, {31'h0, exp_q.size() == 0});
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk32("spurious_out_valid", {31'h0, out_valid}, 32'h0);
                end else begin
                    if (!exp_q[0].seen) begin
                        chk32("latency", cyc - exp_q[0].acc, exp_q[0].lat);
                        exp_q[0].seen = 1'b1;
                    end
                    chk32("result", O, exp_q[0].o);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back('{o: model_o(A, B), lat: model_lat(A, B), acc: cyc, seen: 1'b0});
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int n;
        @(posedge clk);
        #1;
        A = a;
        B = b;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            errors++;
            checks++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = $urandom;
        B = $urandom;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL result_timeout: %0d results pending after %0d cycles", exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    task automatic directed(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] o_exp, input int lat_exp);
        chk32("model_pin_o", model_o(a, b), o_exp);
        chk32("model_pin_lat", model_lat(a, b), lat_exp);
        send(a, b);
        wait_done();
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 9);
        case (k)
            0: begin
                r[30:23] = 8'h00;
                if ($urandom_range(0, 3) == 0) r[22:0] = 23'h0;
            end
            1: begin
                r[30:23] = 8'hFF;
                if ($urandom_range(0, 1) == 0) r[22:0] = 23'h0;
            end
            2: r[30:23] = 8'($urandom_range(240, 254));
            3: r[30:23] = 8'($urandom_range(1, 20));
            default: if (r[30:23] == 8'hFF) r[30:23] = 8'hFE;
        endcase
        return r;
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_valid = 1'b1;
        A = 32'h40C0_0000;
        B = 32'h4000_0000;
        #3;
        chk32("reset_o", O, 32'h0);
        chk32("reset_out_valid", {31'h0, out_valid}, 32'h0);
        chk32("reset_in_ready", {31'h0, in_ready}, 32'h1);
        repeat (3) @(posedge clk);
        chk32("reset_ignores_in_valid", {31'h0, out_valid}, 32'h0);
        #1;
        in_valid = 1'b0;
        n_rst = 1'b1;

        directed(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 28);
        directed(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 28);
        directed(32'h0000_0000, 32'h8000_0000, 32'h7FC0_0000, 1);
        directed(32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1);
        directed(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 1);
        directed(32'h7FA0_0001, 32'h3F80_0000, 32'h7FA0_0001, 1);
        directed(32'h3F80_0000, 32'hFFC0_0123, 32'hFFC0_0123, 1);
        directed(32'hC000_0000, 32'h7F80_0000, 32'h8000_0000, 1);
        directed(32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 28);
        directed(32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 28);
        directed(32'h0000_0001, 32'h0080_0000, 32'h3400_0000, 51);
        directed(32'hC0A0_0000, 32'h4020_0000, 32'hC000_0000, 28);

        // Backpressure: result held for 10 cycles, in_valid pulse must be ignored.
        rdy_mode = 1;
        @(posedge clk);
        send(32'h4110_0000, 32'h4040_0000);
        begin
            int n;
            n = 0;
            while (!out_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) begin
                A = 32'h7FC0_0000;
                B = 32'h3F80_0000;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            chk32("bp_out_valid", {31'h0, out_valid}, 32'h1);
            chk32("bp_o", O, 32'h4040_0000);
        end
        rdy_mode = 0;
        wait_done();

        // Reset in the middle of DIV discards the operation without a clock edge.
        send(32'h3F80_0000, 32'h4040_0000);
        repeat (9) @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        chk32("midrst_o", O, 32'h0);
        chk32("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        chk32("midrst_in_ready", {31'h0, in_ready}, 32'h1);
        exp_q.delete();
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        directed(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 28);

        rdy_mode = 2;
        for (int i = 0; i < 150; i++) begin
            send(rand_op(), rand_op());
            wait_done();
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end
        rdy_mode = 0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
